mpi_mem_map: RTL and testbench

- Parametrised successor to the team's 8-bit MPI slave. Serves a single-port RAM region and a register-file region from one MPI bus, with registered reads and a valid strobe.
- Adds a post-reset RAM clear sequence with a Busy flag, and error flagging for out-of-range register accesses.
- Sits between the MPI bus decoder and the datapath; register contents are exported for control use.

---
 rtl/mpi_mm_pkg.sv | 17 +
 rtl/mpi_mm_spram.sv | 30 +++
 rtl/mpi_mem_map.sv | 190 +++++++++++++++++++
 tb/tb_mpi_mem_map.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mpi_mm_pkg.sv
// Shared constants, FSM state type and parity helper for the mpi_mem_map slave.
package mpi_mm_pkg;

    localparam logic REGION_RAM = 1'b0;
    localparam logic REGION_REG = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    // Even parity over up to 64 bits; callers zero-extend narrower words.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/mpi_mm_spram.sv
// Inferred single-port synchronous RAM; the read register only loads on reads,
// so the last read word is held across writes and idle cycles.
module mpi_mm_spram #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          ce,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (ce) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mpi_mem_map.sv
// MPI slave serving a RAM region and a register-file region with post-reset RAM clear.
// Optional RAM parity checking is enabled with the MPI_MM_PARITY_EN macro.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_INIT | clearing RAM word by word, Busy high, accesses rejected
//   ST_IDLE | serving accesses; left only through Reset
module mpi_mem_map
    import mpi_mm_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int RAM_AW  = 5,
    parameter int REG_NUM = 16
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Mpi_enb,
    input  logic                      Rw,
    input  logic [RAM_AW:0]           Addr_in,
    input  logic [DATA_W-1:0]         Data_in,
    output logic [DATA_W-1:0]         Data_out,
    output logic                      Rd_valid,
    output logic                      Busy,
    output logic                      Err,
`ifdef MPI_MM_PARITY_EN
    output logic [REG_NUM*DATA_W-1:0] Reg_q,
    output logic                      Par_err
`else
    output logic [REG_NUM*DATA_W-1:0] Reg_q
`endif
);

`ifdef MPI_MM_PARITY_EN
    localparam int RAM_W = DATA_W + 1;
`else
    localparam int RAM_W = DATA_W;
`endif
    localparam logic [31:0] REG_LIM = 32'(REG_NUM);

    state_e                      state_q, state_d;
    logic [RAM_AW-1:0]           ptr_q, ptr_d;
    logic [REG_NUM*DATA_W-1:0]   regs_q, regs_d;
    logic                        rd_valid_q, rd_valid_d;
    logic                        err_q, err_d;
    logic                        src_ram_q, src_ram_d;
    logic [DATA_W-1:0]           rd_reg_q, rd_reg_d;

    logic                        acc;
    logic                        region;
    logic [RAM_AW-1:0]           idx;
    logic                        reg_hit;
    logic                        ram_ce, ram_we;
    logic [RAM_AW-1:0]           ram_addr;
    logic [RAM_W-1:0]            ram_wdata, ram_rdata, init_word, wr_word;

`ifdef MPI_MM_PARITY_EN
    logic par_chk_q, par_chk_d;
    logic par_err_q, par_err_d;
    logic par_now;

    assign init_word = {even_par(64'd0), {DATA_W{1'b0}}};
    assign wr_word   = {even_par(64'(Data_in)), Data_in};
`else
    assign init_word = '0;
    assign wr_word   = Data_in;
`endif

    always_comb begin
        acc        = Mpi_enb && !Reset;
        region     = Addr_in[RAM_AW];
        idx        = Addr_in[RAM_AW-1:0];
        reg_hit    = 32'(idx) < REG_LIM;

        state_d    = state_q;
        ptr_d      = ptr_q;
        regs_d     = regs_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        src_ram_d  = src_ram_q;
        rd_reg_d   = rd_reg_q;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = idx;
        ram_wdata  = wr_word;

        case (state_q)
            ST_INIT: begin
                ram_ce    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = ptr_q;
                ram_wdata = init_word;
                ptr_d     = ptr_q + 1'b1;
                err_d     = acc;
                if (ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (acc) begin
                    rd_valid_d = Rw;
                    if (region == REGION_RAM) begin
                        ram_ce = 1'b1;
                        ram_we = !Rw;
                        if (Rw) begin
                            src_ram_d = 1'b1;
                        end
                    end else begin
                        err_d = !reg_hit;
                        if (Rw) begin
                            src_ram_d = 1'b0;
                            rd_reg_d  = '0;
                        end
                        // Unmatched indices fall through, so out-of-range reads give 0.
                        for (int i = 0; i < REG_NUM; i++) begin
                            if (32'(idx) == 32'(i)) begin
                                if (Rw) begin
                                    rd_reg_d = regs_q[i*DATA_W +: DATA_W];
                                end else begin
                                    regs_d[i*DATA_W +: DATA_W] = Data_in;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            regs_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
            src_ram_q  <= 1'b0;
            rd_reg_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            regs_q     <= regs_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
            src_ram_q  <= src_ram_d;
            rd_reg_q   <= rd_reg_d;
        end
    end

    mpi_mm_spram #(
        .DW (RAM_W),
        .AW (RAM_AW)
    ) u_ram (
        .clk   (Clock),
        .ce    (ram_ce),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

`ifdef MPI_MM_PARITY_EN
    always_comb begin
        par_chk_d = acc && (state_q == ST_IDLE) && (region == REGION_RAM) && Rw;
        par_now   = par_chk_q &&
                    (ram_rdata[DATA_W] != even_par(64'(ram_rdata[DATA_W-1:0])));
        par_err_d = par_err_q || par_now;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            par_chk_q <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            par_chk_q <= par_chk_d;
            par_err_q <= par_err_d;
        end
    end

    // Visible already in the Rd_valid cycle of the failing read, sticky afterwards.
    assign Par_err = par_err_q || par_now;
`endif

    assign Data_out = src_ram_q ? ram_rdata[DATA_W-1:0] : rd_reg_q;
    assign Rd_valid = rd_valid_q;
    assign Err      = err_q;
    assign Busy     = (state_q == ST_INIT);
    assign Reg_q    = regs_q;

endmodule

// File: tb/tb_mpi_mem_map.sv
// Self-checking bench for mpi_mem_map: directed table, corner sequences, random traffic vs model.
module tb_mpi_mem_map;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         Mpi_enb;
    logic         Rw;
    logic [5:0]   Addr_in;
    logic [7:0]   Data_in;
    logic [7:0]   Data_out;
    logic         Rd_valid;
    logic         Busy;
    logic         Err;
    logic [127:0] Reg_q;
`ifdef MPI_MM_PARITY_EN
    logic         Par_err;
`endif

    mpi_mem_map #(.DATA_W(8), .RAM_AW(5), .REG_NUM(16)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Mpi_enb  (Mpi_enb),
        .Rw       (Rw),
        .Addr_in  (Addr_in),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .Rd_valid (Rd_valid),
        .Busy     (Busy),
        .Err      (Err),
`ifdef MPI_MM_PARITY_EN
        .Reg_q    (Reg_q),
        .Par_err  (Par_err)
`else
        .Reg_q    (Reg_q)
`endif
    );

    always #5 Clock = ~Clock;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: memory contents, last returned word, remaining clear cycles.
    logic [7:0]   ram_m  [32];
    logic [7:0]   regs_m [16];
    logic [7:0]   last_m;
    int           init_left;
    logic         e_v, e_err, e_busy;
    logic         exp_par;

    typedef struct {
        logic       en;
        logic       rw;
        logic [5:0] addr;
        logic [7:0] din;
        logic [7:0] dout;
        logic       v;
        logic       err;
    } vec_t;

    function automatic logic [127:0] pack_regs();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = regs_m[i];
        return r;
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ram_m[i] = 8'h00;
        for (int i = 0; i < 16; i++) regs_m[i] = 8'h00;
        last_m    = 8'h00;
        init_left = 32;
        exp_par   = 1'b0;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        Mpi_enb = 1'b0;
        Rw      = 1'b0;
        Addr_in = '0;
        Data_in = '0;
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        check("reset_state", {Data_out, Rd_valid, Err, Busy, Reg_q},
              {8'h00, 1'b0, 1'b0, 1'b1, 128'h0});
`ifdef MPI_MM_PARITY_EN
        check("reset_par_err", Par_err, 1'b0);
`endif
    endtask

    // Applies one cycle of stimulus and compares all outputs against the model.
    task automatic step(input logic en, input logic rw, input logic [5:0] a,
                        input logic [7:0] d, input string nm);
        Mpi_enb = en;
        Rw      = rw;
        Addr_in = a;
        Data_in = d;
        e_v     = 1'b0;
        e_err   = 1'b0;
        if (init_left > 0) begin
            e_err = en;
            init_left--;
        end else if (en) begin
            if (a[5] == 1'b0) begin
                if (rw) begin e_v = 1'b1; last_m = ram_m[a[4:0]]; end
                else ram_m[a[4:0]] = d;
            end else if (a[4:0] < 5'd16) begin
                if (rw) begin e_v = 1'b1; last_m = regs_m[a[3:0]]; end
                else regs_m[a[3:0]] = d;
            end else begin
                e_err = 1'b1;
                if (rw) begin e_v = 1'b1; last_m = 8'h00; end
            end
        end
        e_busy = (init_left > 0);
        @(negedge Clock);
        n_vec++;
        if ({Data_out, Rd_valid, Err, Busy} !== {last_m, e_v, e_err, e_busy} ||
            Reg_q !== pack_regs()) begin
            n_bad++;
            $display("FAIL %s: got dout=%h v=%b err=%b busy=%b regq=%h, required dout=%h v=%b err=%b busy=%b regq=%h",
                     nm, Data_out, Rd_valid, Err, Busy, Reg_q, last_m, e_v, e_err, e_busy, pack_regs());
        end
`ifdef MPI_MM_PARITY_EN
        check({nm, "_par_err"}, Par_err, exp_par);
`endif
    endtask

    task automatic run_init(output int busy_cnt);
        busy_cnt = Busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, 6'h00, 8'h00, "init_wait");
            if (Busy) busy_cnt++;
        end
    endtask

    vec_t tbl [11];
    int   bc;

    initial begin
        Reset   = 1'b1;
        Mpi_enb = 1'b0;
        Rw      = 1'b0;
        Addr_in = '0;
        Data_in = '0;
        model_reset();
        repeat (2) @(negedge Clock);

        tbl[0]  = '{1'b1, 1'b1, 6'h07, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 6'h03, 8'hA5, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 6'h03, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 6'h2F, 8'h5A, 8'hA5, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 6'h2F, 8'h00, 8'h5A, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 6'h0F, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 6'h30, 8'hFF, 8'h00, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 6'h30, 8'h00, 8'h00, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 6'h03, 8'h00, 8'h00, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 6'h03, 8'h00, 8'hA5, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 6'h00, 8'h00, 8'hA5, 1'b0, 1'b0};

        do_reset();
        run_init(bc);
        check("busy_cycles", 32'(bc), 32'd32);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].rw, tbl[i].addr, tbl[i].din, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_out", i), {Data_out, Rd_valid, Err},
                  {tbl[i].dout, tbl[i].v, tbl[i].err});
        end
        check("reg15_slice", Reg_q[127:120], 8'h5A);
        check("reg_rest", Reg_q[119:0], 120'h0);

        // Reset in the middle of INIT must restart a full clear and wipe earlier RAM data.
        step(1'b1, 1'b0, 6'h01, 8'h77, "wr_77");
        step(1'b1, 1'b1, 6'h01, 8'h00, "rd_77");
        check("rd_77_val", Data_out, 8'h77);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 6'h00, 8'h00, "init_pre");
        do_reset();
        step(1'b1, 1'b0, 6'h01, 8'h99, "init_wr");
        check("init_wr_err", {Rd_valid, Err}, 2'b01);
        step(1'b1, 1'b1, 6'h2F, 8'h00, "init_rd");
        check("init_rd_err", {Rd_valid, Err}, 2'b01);
        run_init(bc);
        check("busy_cycles_restart", 32'(bc + 2), 32'd32);
        step(1'b1, 1'b1, 6'h01, 8'h00, "rd_cleared");
        check("rd_cleared_val", {Data_out, Rd_valid}, {8'h00, 1'b1});

`ifdef MPI_MM_PARITY_EN
        step(1'b1, 1'b0, 6'h04, 8'h3C, "par_wr");
        dut.u_ram.mem_q[4][8] = ~dut.u_ram.mem_q[4][8];
        exp_par = 1'b1;
        step(1'b1, 1'b1, 6'h04, 8'h00, "par_rd");
        check("par_rd_data", Data_out, 8'h3C);
        step(1'b1, 1'b1, 6'h05, 8'h00, "par_sticky1");
        step(1'b0, 1'b0, 6'h00, 8'h00, "par_sticky2");
        do_reset();
        run_init(bc);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(($urandom % 4) != 0, $urandom % 2, 6'($urandom_range(0, 63)),
                     8'($urandom), "rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
